// File: rtl/iter_counter_pkg.sv
// Shared state encodings and default sizing for the multdiv iteration sequencer.
package iter_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH    = 6;
  localparam bit DEFAULT_FREE_RUN = 1'b0;

endpackage

// File: rtl/up_counter_reg.sv
// WIDTH-bit up counter: async active-low clear, sync clear (wins) and increment enable.
module up_counter_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             i_sclr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      o_count <= '0;
    end else if (i_sclr) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= o_count + ONE;
    end
  end

endmodule

// File: rtl/iter_counter.sv
// Iteration sequencer: start latches a limit, counts enabled cycles 0..limit, pulses done.
// Optional abort input enabled by defining ITER_COUNTER_ABORT_EN.
module iter_counter
  import iter_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter bit FREE_RUN = DEFAULT_FREE_RUN
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             start,
  input  logic             en,
`ifdef ITER_COUNTER_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             last
);

  state_t           r_state;
  logic [WIDTH-1:0] r_limit;
  logic             r_busy;
  logic             r_done;
  logic             w_abort;
  logic             w_term;
  logic             w_run_en;
  logic             w_sclr;
  logic             w_inc;

`ifdef ITER_COUNTER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_term   = (count == r_limit);
  assign w_run_en = (r_state == ST_RUN) && en;

  // Count restarts on any accepted start, on abort, and on the free-running wrap.
  assign w_sclr = ((r_state == ST_IDLE) && start)
                || ((r_state == ST_DONE) && start && !w_abort)
                || ((r_state == ST_RUN) && w_abort)
                || (w_run_en && w_term && FREE_RUN);
  assign w_inc  = w_run_en && !w_term && !w_abort;

  up_counter_reg #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clock   (clock),
    .clr_n   (clr_n),
    .i_sclr  (w_sclr),
    .i_inc   (w_inc),
    .o_count (count)
  );

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
      r_limit <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_limit <= limit;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (en && w_term) begin
            r_done <= 1'b1;
            if (!FREE_RUN) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (start && !w_abort) begin
            r_state <= ST_RUN;
            r_limit <= limit;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign last = r_busy && w_term && en;

endmodule
